mac_kbd_link: RTL
=================

Name: mac_kbd_link

Overview:
- Parametrised Mac Plus keyboard-line transceiver. It generates the keyboard clock, shifts host commands in, and shifts device responses out over the single bidirectional data line.
- Successor to the inline keyboard shifter in the data controller. It adds a configurable bit width and clock rate, a response FIFO in place of the single holding byte, and an inquiry timeout that auto-sends a NULL response.
- Sits between the VIA CB1/CB2 handshake lines and the keyboard module.

Parameters:
- DATA_BITS, 8, bits per transfer; MSB first.
- HALF_PERIOD, 1300, clk_en ticks per keyboard-clock half period. Must be ≥ 2.
- FIFO_DEPTH, 4, response FIFO entries; power of two, ≥ 2.
- TIMEOUT, 2000000, clk_en ticks spent in WAIT_RSP before a NULL response is sent.
- NULL_CODE, 8'h7B, response sent on timeout; low DATA_BITS bits are used.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  8 MHz clock-enable strobe; all protocol timing advances only when this is high
- host_data_i  in  1  resolved data line as driven by the VIA (CB2 tristate-resolved)
- kbd_clk_o  out  1  keyboard clock to VIA CB1
- kbd_data_o  out  1  device-driven data to VIA CB2 input
- cmd_data  out  DATA_BITS  last received host command
- cmd_strobe  out  1  one-clk pulse; cmd_data is valid in the same cycle
- rsp_data  in  DATA_BITS  device response byte
- rsp_strobe  in  1  push rsp_data into the FIFO; sampled every clk, not gated by clk_en
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of entries in the FIFO
- overflow  out  1  one-clk pulse when a push is dropped
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - kbd_clk_o=1, kbd_data_o=1, cmd_data=0, cmd_strobe=0, overflow=0, fifo_level=0, busy=0.
  - Divider, bit counter and timeout counter are all 0.
  - FIFO is flushed.
  - A reset asserted mid-transfer aborts the transfer immediately; no strobe is emitted.
- Divider (TX and RX states only), on each clk_en tick:
  - cnt increments.
  - When cnt==HALF_PERIOD-1: toggle kbd_clk_o and set cnt=0.
  - In all other states: cnt=0 and kbd_clk_o=1.
- Falling edge (the toggle taken while kbd_clk_o=1):
  - TX: shift_reg <= {shift_reg[DATA_BITS-2:0], host_data_i}.
  - RX: kbd_data_o <= shift_reg[DATA_BITS-1-bitcnt].
- Rising edge: bitcnt increments. The rising edge that completes bit DATA_BITS-1 ends the transfer.
- State transitions (evaluated on clk_en unless noted):
  - IDLE → TX when host_data_i==0. bitcnt=0, cnt=0.
  - TX end: cmd_data<=shift_reg and cmd_strobe=1 for one clk in the same cycle; go to WAIT_RSP; timeout counter=0.
  - WAIT_RSP: kbd_clk_o=1. The timeout counter increments per clk_en and saturates at TIMEOUT.
    - If host_data_i==1 and FIFO is not empty: pop the head into shift_reg, go to RX.
    - Else if host_data_i==1 and timeout==TIMEOUT: load NULL_CODE into shift_reg, go to RX; the FIFO is untouched.
    - While host_data_i==0, the Mac is still holding the line, so the state stays WAIT_RSP.
  - RX end: kbd_data_o=1, go to IDLE.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - A push while full is dropped and overflow pulses.
  - A push and a pop in the same clk while full: the pop frees an entry, the push is accepted, and fifo_level is unchanged.
  - A push and a pop while the FIFO is empty is not possible, because a pop requires non-empty.
  - fifo_level updates the cycle after a push or pop.
- Responses pushed during TX or RX queue normally and are not lost.

Test Plan:
- HALF_PERIOD=4, DATA_BITS=8. Bench pulls host_data_i low, then drives 0x14 MSB-first, changing the bit only while kbd_clk_o is high → cmd_strobe pulses once with cmd_data=0x14, exactly 64 clk_en ticks after TX entry; state is WAIT_RSP.
- After the previous case: push rsp 0x33, release host_data_i high → 8 kbd_clk_o cycles follow; kbd_data_o, sampled on each rising edge, reads 0,0,1,1,0,0,1,1; ends with kbd_data_o=1, busy=0, fifo_level=0.
- TIMEOUT=100, FIFO empty, host high in WAIT_RSP → RX starts on the 100th clk_en tick and sends 0x7B.
- FIFO_DEPTH=4: push 5 bytes back-to-back while IDLE → fifo_level=4 and overflow pulses once. Then push and pop in the same cycle while full → level stays 4, no overflow, data order preserved.
- Assert reset for 1 clk at bit 3 of RX → next cycle kbd_clk_o=1, kbd_data_o=1, fifo_level=0, busy=0, and no cmd_strobe occurs.
- DATA_BITS=10, HALF_PERIOD=2: round-trip 0x2A5 → cmd_data=0x2A5 after 40 clk_en ticks.

Source files
------------

// File: rtl/mac_kbd_link_if.sv
// Mac Plus keyboard-line bundle: serial line, command/response bus
// and FIFO status between the VIA side and the keyboard model.
interface mac_kbd_link_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic                 host_data_i;
    logic                 kbd_clk_o;
    logic                 kbd_data_o;
    logic [DATA_BITS-1:0] cmd_data;
    logic                 cmd_strobe;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 rsp_strobe;
    logic [LW-1:0]        fifo_level;
    logic                 overflow;
    logic                 busy;

    modport master (
        output host_data_i,
        output rsp_data,
        output rsp_strobe,
        input  kbd_clk_o,
        input  kbd_data_o,
        input  cmd_data,
        input  cmd_strobe,
        input  fifo_level,
        input  overflow,
        input  busy
    );

    modport slave (
        input  host_data_i,
        input  rsp_data,
        input  rsp_strobe,
        output kbd_clk_o,
        output kbd_data_o,
        output cmd_data,
        output cmd_strobe,
        output fifo_level,
        output overflow,
        output busy
    );
endinterface

// File: rtl/mac_kbd_link.sv
// Mac Plus keyboard-line transceiver: clock generation, host command
// shift-in, FIFO-backed response shift-out with inquiry timeout.
module mac_kbd_link #(
    parameter int          DATA_BITS   = 8,
    parameter int          HALF_PERIOD = 1300,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TIMEOUT     = 2000000,
    parameter logic [31:0] NULL_CODE   = 32'h7B
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    mac_kbd_link_if.slave bus
);
    localparam int CW = $clog2(HALF_PERIOD);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DATA_BITS-1:0] NULL_V = DATA_BITS'(NULL_CODE);
    localparam logic [CW-1:0]        HALF_M1 = CW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0]        LAST_B  = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0]        TO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [TW-1:0]        r_to;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_kclk;
    logic                 r_kdat;
    logic [DATA_BITS-1:0] r_cmd;
    logic                 r_cstb;
    logic                 r_busy;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wp;
    logic [PW-1:0]        r_rp;
    logic [LW-1:0]        r_level;
    logic                 r_ovf;

    logic                 w_host;
    logic                 w_half;
    logic                 w_last;
    logic [BW-1:0]        w_rx_idx;
    logic [TW-1:0]        w_to_nxt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_head;

    assign w_host   = bus.host_data_i;
    assign w_half   = (r_cnt == HALF_M1);
    assign w_last   = (r_bit == LAST_B);
    assign w_rx_idx = LAST_B - r_bit;
    assign w_to_nxt = (r_to == TO_MAX) ? r_to : r_to + TW'(1);

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_head  = r_mem[r_rp[AW-1:0]];

    // Pop mirrors the FSM's WAIT_RSP dequeue condition exactly.
    assign w_pop  = clk_en && (r_state == S_WAIT) &&
                    w_host && !w_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_push = bus.rsp_strobe && (!w_full || w_pop);

    // Line FSM: divider, bit shifting, command capture and response select.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_to    <= '0;
            r_shift <= '0;
            r_kclk  <= 1'b1;
            r_kdat  <= 1'b1;
            r_cmd   <= '0;
            r_cstb  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cstb <= 1'b0;
            if (clk_en) begin
                unique case (r_state)
                    S_IDLE: begin
                        r_cnt  <= '0;
                        r_kclk <= 1'b1;
                        if (!w_host) begin
                            r_state <= S_TX;
                            r_bit   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_TX, S_RX: begin
                        if (w_half) begin
                            r_cnt  <= '0;
                            r_kclk <= ~r_kclk;
                            if (r_kclk) begin
                                if (r_state == S_TX)
                                    r_shift <= {r_shift[DATA_BITS-2:0],
                                                w_host};
                                else
                                    r_kdat <= r_shift[w_rx_idx];
                            end else if (!w_last) begin
                                r_bit <= r_bit + BW'(1);
                            end else if (r_state == S_TX) begin
                                r_cmd   <= r_shift;
                                r_cstb  <= 1'b1;
                                r_to    <= '0;
                                r_state <= S_WAIT;
                            end else begin
                                r_kdat  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_WAIT: begin
                        r_cnt  <= '0;
                        r_kclk <= 1'b1;
                        r_to   <= w_to_nxt;
                        if (w_host && !w_empty) begin
                            r_shift <= w_head;
                            r_bit   <= '0;
                            r_state <= S_RX;
                        end else if (w_host && w_to_nxt == TO_MAX) begin
                            r_shift <= NULL_V;
                            r_bit   <= '0;
                            r_state <= S_RX;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Response FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= bus.rsp_strobe && w_full && !w_pop;
            if (w_push)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage; contents are dead once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= bus.rsp_data;
    end

    assign bus.kbd_clk_o  = r_kclk;
    assign bus.kbd_data_o = r_kdat;
    assign bus.cmd_data   = r_cmd;
    assign bus.cmd_strobe = r_cstb;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = r_busy;

endmodule
